// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch stage
// (reads only) and the execute stage (loads, plus read-modify-write stores).
// Only one backend transaction is ever in flight. Contention in IDLE is broken
// round-robin, and a store's write-back is issued before any new read is granted.
// All outputs are registered and arb_state exposes the FSM state for debug.
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int READ_ADDR_SIZE = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  // fetch stage
  input  logic                      fetch_readEn,
  input  logic [READ_ADDR_SIZE-1:0] fetch_readAddr,
  output logic                      fetch_readFin,
  output logic [XLEN-1:0]           fetch_readData,
  // execute stage
  input  logic                      exec_readEn,
  input  logic [READ_ADDR_SIZE-1:0] exec_readAddr,
  input  logic                      exec_writeEn,
  input  logic [READ_ADDR_SIZE-1:0] exec_writeAddr,
  input  logic [XLEN-1:0]           exec_writeData,
  output logic                      exec_readFin,
  output logic [XLEN-1:0]           exec_readData,
  // memory backend
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [READ_ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  input  logic                      mem_ack,
  input  logic [XLEN-1:0]           mem_rdata,
  // debug
  output logic [2:0]                arb_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    F_BUSY  = 3'd1,
    F_DONE  = 3'd2,
    E_BUSY  = 3'd3,
    E_DONE  = 3'd4,
    WR_BUSY = 3'd5
  } state_e;

  // Which requester won the most recent grant.
  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_EXEC  = 1'b1;

  state_e                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic                      wr_pending_q, wr_pending_d;
  // High only during the first cycle spent in E_DONE; the single cycle in
  // which a store's write request is accepted.
  logic                      e_entry_q, e_entry_d;
  logic [READ_ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]           wr_data_q, wr_data_d;

  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [READ_ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]           mem_wdata_q, mem_wdata_d;
  logic                      f_fin_q, f_fin_d;
  logic                      e_fin_q, e_fin_d;
  logic [XLEN-1:0]           f_data_q, f_data_d;
  logic [XLEN-1:0]           e_data_q, e_data_d;

  logic                      wr_take;
  logic                      grant_exec;

  // Next-state and next-output logic; every register holds unless a state acts.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_pending_d = wr_pending_q;
    e_entry_d    = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    f_fin_d      = f_fin_q;
    e_fin_d      = e_fin_q;
    f_data_d     = f_data_q;
    e_data_d     = e_data_q;
    wr_take      = 1'b0;
    // Execute wins when alone, or on contention when fetch had the last grant.
    grant_exec   = exec_readEn && (!fetch_readEn || (last_grant_q == GNT_FETCH));

    unique case (state_q)
      IDLE: begin
        if (grant_exec) begin
          state_d      = E_BUSY;
          last_grant_d = GNT_EXEC;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = exec_readAddr;
        end else if (fetch_readEn) begin
          state_d      = F_BUSY;
          last_grant_d = GNT_FETCH;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = fetch_readAddr;
        end
      end

      F_BUSY: begin
        if (mem_ack) begin
          f_data_d  = mem_rdata;
          f_fin_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = F_DONE;
        end
      end

      F_DONE: begin
        if (!fetch_readEn) begin
          f_fin_d = 1'b0;
          state_d = IDLE;
        end
      end

      E_BUSY: begin
        if (mem_ack) begin
          e_data_d  = mem_rdata;
          e_fin_d   = 1'b1;
          mem_req_d = 1'b0;
          e_entry_d = 1'b1;
          state_d   = E_DONE;
        end
      end

      E_DONE: begin
        // Only the entry cycle may latch a write, so a stalled execute stage
        // holding writeEn high still produces exactly one write-back.
        wr_take = e_entry_q && exec_writeEn;
        if (wr_take) begin
          wr_addr_d    = exec_writeAddr;
          wr_data_d    = exec_writeData;
          wr_pending_d = 1'b1;
        end
        if (!exec_readEn) begin
          e_fin_d = 1'b0;
          if (wr_pending_q || wr_take) begin
            state_d     = WR_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_take ? exec_writeAddr : wr_addr_q;
            mem_wdata_d = wr_take ? exec_writeData : wr_data_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      WR_BUSY: begin
        if (mem_ack) begin
          wr_pending_d = 1'b0;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        f_fin_d   = 1'b0;
        e_fin_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight or pending work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FETCH;
      wr_pending_q <= 1'b0;
      e_entry_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      f_fin_q      <= 1'b0;
      e_fin_q      <= 1'b0;
      f_data_q     <= '0;
      e_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_pending_q <= wr_pending_d;
      e_entry_q    <= e_entry_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      f_fin_q      <= f_fin_d;
      e_fin_q      <= e_fin_d;
      f_data_q     <= f_data_d;
      e_data_q     <= e_data_d;
    end
  end

  assign fetch_readFin  = f_fin_q;
  assign fetch_readData = f_data_q;
  assign exec_readFin   = e_fin_q;
  assign exec_readData  = e_data_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign arb_state      = state_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the fetch stage (read-only) and the execute stage (load, plus read-modify-write store).
- Sits between both pipeline stages and the memory backend.
- Sequences execute's store write-back after its read phase.
- Arbitrates concurrent fetch/execute requests round-robin and keeps memory accesses in program order.

Parameters:
- XLEN, 32, data width.
- READ_ADDR_SIZE, 32, address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- fetch_readEn  input  1  fetch read request, held until fetch_readFin seen.
- fetch_readAddr  input  READ_ADDR_SIZE  fetch address, stable while fetch_readEn.
- fetch_readFin  output  1  fetch read complete.
- fetch_readData  output  XLEN  fetch read data.
- exec_readEn  input  1  execute read request (load and store phase 1), held until done.
- exec_readAddr  input  READ_ADDR_SIZE  execute read address.
- exec_writeEn  input  1  store write request, valid only while exec_readFin=1.
- exec_writeAddr  input  READ_ADDR_SIZE  store address.
- exec_writeData  input  XLEN  merged store word.
- exec_readFin  output  1  execute read complete.
- exec_readData  output  XLEN  execute read data.
- mem_req  output  1  backend request, held until mem_ack.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  READ_ADDR_SIZE  backend address.
- mem_wdata  output  XLEN  backend write data.
- mem_ack  input  1  one-cycle completion pulse; mem_rdata valid with it.
- mem_rdata  input  XLEN  backend read data.
- arb_state  output  3  current state, debug.

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high.
- Reset values: all outputs registered; all 0. State=IDLE, last_grant=FETCH, wr_pending=0.
- States: IDLE=0, F_BUSY=1, F_DONE=2, E_BUSY=3, E_DONE=4, WR_BUSY=5.

IDLE:
- Only exec_readEn -> E_BUSY.
- Only fetch_readEn -> F_BUSY.
- Both -> grant the requester opposite last_grant. First contention after reset goes to execute.
- On grant: update last_grant; next cycle mem_req=1, mem_we=0, mem_addr=granted address.

x_BUSY (read):
- Hold mem_req/mem_addr stable.
- On mem_ack: capture mem_rdata into x_readData, drop mem_req, go to x_DONE.
- Latency: request sampled cycle N; mem_req from N+1; ack in cycle k; Fin from k+1. Minimum 2 cycles request-to-Fin.

F_DONE:
- fetch_readFin=1 while fetch_readEn=1.
- When fetch_readEn=0: Fin=0, go to IDLE.

E_DONE:
- exec_readFin=1 while exec_readEn=1; execute may stall with Fin held.
- On the entry cycle only: if exec_writeEn=1, latch writeAddr/writeData and set wr_pending. Later cycles' writeEn are ignored, so one write per store.
- When exec_readEn=0: Fin=0; go to WR_BUSY (mem_req=1, mem_we=1, latched addr/data) if wr_pending, else IDLE.

WR_BUSY:
- Hold until mem_ack, then clear wr_pending, mem_we=0, go to IDLE.
- No read is granted while WR_BUSY, so a fetch of a just-stored word sees the new data.

General rules:
- A request that drops before grant is not serviced.
- At most one transaction outstanding.
- mem_ack outside a BUSY state is ignored.
- x_readData holds its value until the next completion.
- Reset mid-operation: next cycle IDLE, mem_req=0, Fin=0, pending write discarded. A stale ack after reset is ignored.

Test Plan:
- Lone exec load: exec_readEn=1, addr 0x100 at cycle 0; ack at cycle 3 with rdata 0xDEADBEEF -> mem_req=1, we=0, addr 0x100 for cycles 1-3; exec_readFin=1, data 0xDEADBEEF from cycle 4 until exec_readEn drops; then IDLE.
- Contention after reset: both request at cycle 0 (fetch 0x0, exec 0x200) -> exec serviced first. Fetch granted the cycle after exec_readEn drops; fetch_readFin follows its ack.
- Fairness: both continuously re-request after each completion -> grants alternate exec, fetch, exec, fetch.
- Store: exec read 0x104 completes; writeEn=1, writeAddr 0x104, writeData 0x12345678 in the Fin cycle; Fin held 2 cycles -> one mem write only, we=1, addr 0x104, wdata 0x12345678. A fetch asserted during the write is granted only after the write ack.
- Reset mid-op: rst=1 in E_BUSY, ack arrives next cycle -> mem_req=0, exec_readFin=0, arb_state=0, exec_readData unchanged from reset value 0.
- Slow ack: ack delayed 20 cycles -> mem_req, addr and we stable throughout; no Fin before ack.
